// File: rtl/bus_out_buffer.sv
// Output data buffer: the datapath writes results with a strobe, and a small FIFO
// presents them to an external consumer over a valid/ready handshake.
module bus_out_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic [WIDTH-1:0]         A,
  input  logic                     Wr,
  output logic                     Full,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  input  logic                     ClrOvf,
  output logic [WIDTH-1:0]         Q,
  output logic                     Valid,
  input  logic                     Ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [DEPTH-1:0] wr_en;
  logic             push, pop;

  assign Full  = (count_q == CW'(DEPTH));
  assign Valid = (count_q != '0);
  assign Count = count_q;
  assign Overflow = ovf_q;
  assign Q     = mem_q[rd_ptr_q];

  // Full/Valid are from the registered count, so a same-cycle pop never makes room.
  assign push = Wr && !Full;
  assign pop  = Valid && Ready;

  always_comb begin
    wr_en    = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_en[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (Wr && Full) begin
      ovf_d = 1'b1;
    end else if (ClrOvf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_q[i] <= A;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_out_buffer.sv
// Bench for bus_out_buffer: table-driven directed rows, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_bus_out_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             Clock = 1'b0;
  logic             Resetn = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic             Wr = 1'b0;
  logic             Full;
  logic [2:0]       Count;
  logic             Overflow;
  logic             ClrOvf = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             Valid;
  logic             Ready = 1'b0;

  bus_out_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .Resetn(Resetn), .A(A), .Wr(Wr), .Full(Full), .Count(Count),
    .Overflow(Overflow), .ClrOvf(ClrOvf), .Q(Q), .Valid(Valid), .Ready(Ready)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of words plus the sticky overflow bit.
  logic [7:0] mq[$];
  logic       movf = 1'b0;
  logic [7:0] popped[$];

  typedef struct {
    logic       wr;
    logic [7:0] a;
    logic       rdy;
    logic       clr;
    int         cnt;
    logic       v;
    logic       f;
    logic       o;
    logic [7:0] q;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic wr, input logic [7:0] a, input logic rdy, input logic clr);
    logic full, pop, push;
    Wr = wr; A = a; Ready = rdy; ClrOvf = clr;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy;
    push = wr && !full;
    if (pop) begin
      popped.push_back(Q);
      void'(mq.pop_front());
    end
    if (wr && full) movf = 1'b1;
    else if (clr)   movf = 1'b0;
    if (push) mq.push_back(a);
    @(posedge Clock);
    #1;
    Wr = 1'b0; Ready = 1'b0; ClrOvf = 1'b0;
    $display("cycle wr=%0b a=%02h rdy=%0b clr=%0b -> cnt=%0d valid=%0b full=%0b ovf=%0b q=%02h",
             wr, a, rdy, clr, Count, Valid, Full, Overflow, Q);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, int'(Count), mq.size());
    chk({tag, ".valid"}, int'(Valid), int'(mq.size() != 0));
    chk({tag, ".full"},  int'(Full),  int'(mq.size() == DEPTH));
    chk({tag, ".ovf"},   int'(Overflow), int'(movf));
    if (mq.size() != 0) chk({tag, ".q"}, int'(Q), int'(mq[0]));
  endtask

  // Drop reset between edges and verify outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    #3;
    Resetn = 1'b0;
    mq.delete();
    movf = 1'b0;
    #1;
    chk({tag, ".q"},     int'(Q), 0);
    chk({tag, ".valid"}, int'(Valid), 0);
    chk({tag, ".full"},  int'(Full), 0);
    chk({tag, ".count"}, int'(Count), 0);
    chk({tag, ".ovf"},   int'(Overflow), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int idx;
    logic wr, rdy, clr;

    // wr a rdy clr | cnt v f o q
    tbl.push_back('{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'hA5});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'hA5});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 8'h01, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h01});
    tbl.push_back('{1'b1, 8'h02, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 8'h01});
    tbl.push_back('{1'b1, 8'h03, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 8'h01});
    tbl.push_back('{1'b1, 8'h04, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 8'h01});
    tbl.push_back('{1'b1, 8'h05, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, 8'h01});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1, 8'h02});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b1, 8'h03});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 8'h04});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 8'h10, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h10});
    tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 8'h10});
    tbl.push_back('{1'b1, 8'h12, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 8'h11});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h12});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00});

    // Power-on reset: outputs must be cleared before any clock edge.
    #2;
    chk("por.q", int'(Q), 0);
    chk("por.valid", int'(Valid), 0);
    chk("por.full", int'(Full), 0);
    chk("por.count", int'(Count), 0);
    chk("por.ovf", int'(Overflow), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock);
    #1;

    foreach (tbl[i]) begin
      tick(tbl[i].wr, tbl[i].a, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d.count", i), int'(Count), tbl[i].cnt);
      chk($sformatf("tbl%0d.valid", i), int'(Valid), int'(tbl[i].v));
      chk($sformatf("tbl%0d.full", i),  int'(Full),  int'(tbl[i].f));
      chk($sformatf("tbl%0d.ovf", i),   int'(Overflow), int'(tbl[i].o));
      if (tbl[i].v) chk($sformatf("tbl%0d.q", i), int'(Q), int'(tbl[i].q));
    end

    // Full + Wr + Ready: only the pop happens, and Overflow is set.
    for (int i = 0; i < 4; i++) tick(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    chk("fullpp.pre_full", int'(Full), 1);
    tick(1'b1, 8'h34, 1'b1, 1'b0);
    chk("fullpp.count", int'(Count), 3);
    chk("fullpp.ovf", int'(Overflow), 1);
    chk("fullpp.q", int'(Q), 8'h31);
    tick(1'b1, 8'h35, 1'b0, 1'b0);
    chk("refill.count", int'(Count), 4);
    // ClrOvf on the same edge as a write-while-full: set wins.
    tick(1'b1, 8'h36, 1'b0, 1'b1);
    chk("setwins.ovf", int'(Overflow), 1);
    chk("setwins.count", int'(Count), 4);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr.ovf", int'(Overflow), 0);
    check_model("clr");

    // Reset with words in flight, then a single write after release.
    async_reset("rst0");
    for (int i = 0; i < 3; i++) tick(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    chk("midrst.pre_count", int'(Count), 3);
    async_reset("midrst");
    tick(1'b1, 8'h7E, 1'b0, 1'b0);
    chk("after_rst.count", int'(Count), 1);
    chk("after_rst.valid", int'(Valid), 1);
    chk("after_rst.q", int'(Q), 8'h7E);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("after_rst.drained", int'(Count), 0);

    // Stream 20..29 through the pointer wrap with Ready toggling.
    popped.delete();
    idx = 0;
    for (int c = 0; c < 80 && (idx < 10 || mq.size() != 0); c++) begin
      rdy = c[0];
      wr  = (idx < 10) && (mq.size() < DEPTH);
      tick(wr, 8'h20 + 8'(idx), rdy, 1'b0);
      if (wr) idx++;
      check_model("wrap");
    end
    chk("wrap.n_popped", popped.size(), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      chk($sformatf("wrap.word%0d", i), int'(popped[i]), 8'h20 + i);
    chk("wrap.ovf", int'(Overflow), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      wr  = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 50);
      clr = ($urandom_range(0, 99) < 8);
      tick(wr, 8'($urandom), rdy, clr);
      check_model("rand");
      if (c == 300) async_reset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_out_buffer.md
Name: bus_out_buffer

Overview:
- Output-side counterpart to the processor's input data register.
- The datapath writes 8-bit results into this block with a write strobe.
- The block buffers them in a small FIFO and presents them to an external consumer over a valid/ready handshake.
- It decouples processor result timing from the consumer's acceptance rate and reports full/overflow status back to the control unit.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of FIFO entries; must be a power of 2, at least 2.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- A  input  WIDTH  write data from the processor datapath.
- Wr  input  1  write strobe; one word per cycle when high.
- Full  output  1  high when DEPTH words are held.
- Count  output  log2(DEPTH)+1  number of words held, 0..DEPTH.
- Overflow  output  1  sticky flag: a write was attempted while Full.
- ClrOvf  input  1  synchronous clear of Overflow.
- Q  output  WIDTH  head-of-queue data to the consumer.
- Valid  output  1  high when Q holds a real word (Count != 0).
- Ready  input  1  consumer accepts Q this cycle when Valid is high.

Behaviour:
- Reset is asynchronous on Resetn low and takes effect immediately, including mid-transfer:
  - read and write pointers go to 0 and Count to 0;
  - all storage entries go to 0;
  - Overflow goes to 0;
  - resulting outputs: Full=0, Valid=0, Q=0.
- Reset is released synchronously to Clock; the first edge with Resetn high may accept a write.
- Push: Wr=1 and Full=0 at a rising edge.
  - A is stored at the write pointer.
  - The write pointer increments modulo DEPTH.
- Pop: Valid=1 and Ready=1 at a rising edge.
  - The read pointer increments modulo DEPTH.
  - The popped word is considered consumed at that edge.
- Write while full: Wr=1 with Full=1.
  - The data is dropped; storage and pointers are unchanged.
  - Overflow is set at that edge.
  - A same-cycle pop does not make room: the Full value sampled that cycle governs.
- Count update per edge:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on both or neither.
- Push and pop in the same cycle (0 < Count < DEPTH): both occur and Count is unchanged.
- Push while empty:
  - Valid rises the cycle after the push edge, with Q equal to the pushed word (latency 1).
  - There is no combinational bypass from A to Q.
- Q is driven combinationally from the storage entry at the read pointer.
  - While Valid=1, Q is stable until a pop edge.
  - While Valid=0, Q shows the stale entry at the read pointer (0 after reset); the consumer must ignore it.
- Ready while Valid=0 is ignored: no pointer change and no underflow.
- Full = (Count == DEPTH); Valid = (Count != 0). Both are decoded from registered Count, so they are glitch-free relative to Clock.
- Overflow:
  - set by a write while full;
  - cleared by ClrOvf=1 at an edge;
  - if set and clear occur in the same cycle, set wins.
- Pointer wrap: pointers are log2(DEPTH) bits and roll over naturally. Ordering is strictly FIFO across wrap.
- Wr and Ready are sampled only at rising edges; mid-cycle glitches have no effect.

Test Plan:
- Reset check:
  - Stimulus: drive Resetn=0 asynchronously between edges.
  - Response: Q=0, Valid=0, Full=0, Count=0 and Overflow=0 immediately, without waiting for a clock edge.
- Single-word latency:
  - Stimulus: one cycle of Wr=1 with A=8'hA5, Ready=0.
  - Response: the next cycle shows Valid=1, Q=8'hA5, Count=1. Holding Ready=0 keeps Q=8'hA5 for 5 cycles.
  - Then Ready=1 for one cycle: Valid=0, Count=0.
- Fill and overflow:
  - Stimulus: write 8'h01..8'h04 on consecutive cycles with Ready=0.
  - Response: Full=1, Count=4.
  - Then write 8'h05: Overflow=1 and Count stays 4.
  - Drain with Ready=1: outputs 01,02,03,04 in order; 05 never appears.
- Simultaneous push/pop:
  - Stimulus: with Count=2 (8'h10, 8'h11 held), assert Wr=1 (A=8'h12) and Ready=1 in the same cycle.
  - Response: Count stays 2 and Q becomes 8'h11. Next pop gives 8'h12.
  - At Count=4, Wr+Ready gives a pop only, with Overflow=1.
- Wrap-around ordering:
  - Stimulus: stream 8'h20..8'h29 (10 words) with Ready toggling every cycle.
  - Response: the consumer sees 20..29 in exact order, no duplicates or gaps, and Overflow remains 0.
- Reset mid-stream and Overflow clear priority:
  - Stimulus: with Count=3, pulse Resetn low.
  - Response: all state clears; the next write of 8'h7E appears alone, with Count=1.
  - Separately, assert ClrOvf on the same edge as a write-while-full: Overflow stays 1.
  - ClrOvf alone on a later edge: Overflow clears to 0.
